// File: rtl/hub_fwd_scheduler_if.sv
// rtl/hub_fwd_scheduler_if.sv - port-side bundle between receive ports, scheduler, distributor and egress FIFOs
//
// Signals:
//   rec_complete [3:0]  one-cycle pulse per source port: packet fully received
//   dst_sel      [7:0]  2-bit destination per source port, bits [2i+1:2i] = port i
//   dst_bcast    [3:0]  broadcast flag per source port
//   egress_full  [3:0]  full flag of each egress FIFO
//   grant        [3:0]  one-hot distributor source select, 0 when idle
//   wr_en        [3:0]  one-cycle write strobe per egress FIFO
//   pending      [3:0]  latched-but-unserved packet flags
//   busy                scheduler not idle
//   drop_cnt            saturating dropped/overrun packet count
// Modports: master = port/FIFO side, slave = scheduler.
interface hub_fwd_scheduler_if #(
    parameter int DROP_CNT_W = 8
);
    logic [3:0]            rec_complete;
    logic [7:0]            dst_sel;
    logic [3:0]            dst_bcast;
    logic [3:0]            egress_full;
    logic [3:0]            grant;
    logic [3:0]            wr_en;
    logic [3:0]            pending;
    logic                  busy;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output rec_complete, dst_sel, dst_bcast, egress_full,
        input  grant, wr_en, pending, busy, drop_cnt
    );

    modport slave (
        input  rec_complete, dst_sel, dst_bcast, egress_full,
        output grant, wr_en, pending, busy, drop_cnt
    );
endinterface

// File: rtl/hub_fwd_scheduler.sv
// rtl/hub_fwd_scheduler.sv - round-robin scheduler sharing the hub distribution path among four ports
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    hub_fwd_scheduler_if.slave (rec_complete, dst_sel, dst_bcast, egress_full in;
//          grant, wr_en, pending, busy, drop_cnt out)
// Parameters:
//   HOLD_CYCLES  cycles grant is held before the write strobe (min 1)
//   DROP_CNT_W   width of the saturating drop counter
// Optional feature macro: HUB_SCHED_FULL_WAIT_EN
//   defined   - WRITE waits (grant held, wr_en low) until no target FIFO is full
//   undefined - targets that are full are skipped and the packet counts as a drop
module hub_fwd_scheduler #(
    parameter int HOLD_CYCLES = 2,
    parameter int DROP_CNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    hub_fwd_scheduler_if.slave  bus
);
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, WRITE, RELEASE} state_t;

    state_t                state;
    logic [1:0]            src;
    logic [1:0]            rr;
    logic [HCW-1:0]        hold_cnt;
    logic [3:0]            pending;
    logic [3:0]            grant;
    logic [3:0]            wr_en;
    logic [1:0]            dst_q [4];
    logic [3:0]            bcast_q;
    logic [DROP_CNT_W-1:0] drop_cnt;
`ifdef HUB_SCHED_FULL_WAIT_EN
    logic [3:0]            mask_q;
    logic                  waiting;
`endif

    function automatic logic [3:0] onehot(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

    // Port being released this cycle; its clear and a fresh capture may coincide.
    logic [3:0] rel_mask;
    logic [3:0] set_mask;
    logic [3:0] overrun;
    assign rel_mask = (state == RELEASE) ? onehot(src) : 4'b0000;
    assign set_mask = bus.rec_complete & (~pending | rel_mask);
    assign overrun  = bus.rec_complete & pending & ~rel_mask;

    // Round-robin pick: first pending port after rr, wrapping modulo 4.
    logic       pick_found;
    logic [1:0] pick_src;
    logic [1:0] cand;
    always_comb begin
        pick_found = 1'b0;
        pick_src   = rr;
        cand       = rr;
        for (int k = 1; k <= 4; k++) begin
            cand = rr + 2'(k);
            if (!pick_found && pending[cand]) begin
                pick_found = 1'b1;
                pick_src   = cand;
            end
        end
    end

    // Destination mask for the packet currently held by src.
    logic [3:0] mask;
    always_comb begin
        mask = 4'b0000;
        if (bcast_q[src])
            mask = ~onehot(src);
        else if (dst_q[src] != src)
            mask = onehot(dst_q[src]);
    end

    logic hold_done;
    assign hold_done = (hold_cnt == HCW'(HOLD_CYCLES - 1));

    // The drop decision is taken on the GRANT->WRITE edge, with the strobe.
    logic write_drop;
`ifdef HUB_SCHED_FULL_WAIT_EN
    assign write_drop = (state == GRANT) && hold_done && (mask == 4'b0000);
`else
    assign write_drop = (state == GRANT) && hold_done &&
                        ((mask == 4'b0000) || ((mask & bus.egress_full) != 4'b0000));
`endif

    // Overruns on several ports and a write drop can land in one cycle; add them all.
    logic [2:0]              inc;
    logic [DROP_CNT_W+2:0]   drop_sum;
    logic [DROP_CNT_W-1:0]   drop_next;
    assign inc = {2'b00, overrun[0]} + {2'b00, overrun[1]} + {2'b00, overrun[2]} +
                 {2'b00, overrun[3]} + {2'b00, write_drop};
    assign drop_sum  = {3'b000, drop_cnt} + {DROP_CNT_W'(0), inc};
    assign drop_next = (drop_sum[DROP_CNT_W+2:DROP_CNT_W] != 3'b000) ? '1
                                                                      : drop_sum[DROP_CNT_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            src      <= 2'd0;
            rr       <= 2'd3;
            hold_cnt <= '0;
            pending  <= 4'b0000;
            grant    <= 4'b0000;
            wr_en    <= 4'b0000;
            bcast_q  <= 4'b0000;
            drop_cnt <= '0;
            for (int i = 0; i < 4; i++) dst_q[i] <= 2'd0;
`ifdef HUB_SCHED_FULL_WAIT_EN
            mask_q   <= 4'b0000;
            waiting  <= 1'b0;
`endif
        end else begin
            pending  <= (pending & ~rel_mask) | set_mask;
            drop_cnt <= drop_next;
            for (int i = 0; i < 4; i++) begin
                if (set_mask[i]) begin
                    dst_q[i]   <= bus.dst_sel[2*i +: 2];
                    bcast_q[i] <= bus.dst_bcast[i];
                end
            end

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        src      <= pick_src;
                        grant    <= onehot(pick_src);
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (hold_done) begin
                        state <= WRITE;
`ifdef HUB_SCHED_FULL_WAIT_EN
                        mask_q <= mask;
                        if (mask == 4'b0000) begin
                            wr_en   <= 4'b0000;
                            waiting <= 1'b0;
                        end else if ((mask & bus.egress_full) != 4'b0000) begin
                            wr_en   <= 4'b0000;
                            waiting <= 1'b1;
                        end else begin
                            wr_en   <= mask;
                            waiting <= 1'b0;
                        end
`else
                        wr_en <= mask & ~bus.egress_full;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WRITE: begin
`ifdef HUB_SCHED_FULL_WAIT_EN
                    if (!waiting) begin
                        wr_en <= 4'b0000;
                        state <= RELEASE;
                    end else if ((mask_q & bus.egress_full) == 4'b0000) begin
                        wr_en   <= mask_q;
                        waiting <= 1'b0;
                    end
`else
                    wr_en <= 4'b0000;
                    state <= RELEASE;
`endif
                end
                RELEASE: begin
                    grant <= 4'b0000;
                    rr    <= src;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant    = grant;
    assign bus.wr_en    = wr_en;
    assign bus.pending  = pending;
    assign bus.busy     = (state != IDLE);
    assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_hub_fwd_scheduler.sv
// tb/tb_hub_fwd_scheduler.sv - directed self-checking bench for hub_fwd_scheduler
module tb_hub_fwd_scheduler;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hub_fwd_scheduler_if #(.DROP_CNT_W(8)) bus  ();
    hub_fwd_scheduler_if #(.DROP_CNT_W(2)) bus2 ();

    hub_fwd_scheduler #(.HOLD_CYCLES(2), .DROP_CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    hub_fwd_scheduler #(.HOLD_CYCLES(2), .DROP_CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] rc, input logic [7:0] ds, input logic [3:0] bc);
        bus.rec_complete = rc;
        bus.dst_sel      = ds;
        bus.dst_bcast    = bc;
        step();
        bus.rec_complete = 4'b0000;
    endtask

    task automatic pulse2(input logic [3:0] rc, input logic [7:0] ds, input logic [3:0] bc);
        bus2.rec_complete = rc;
        bus2.dst_sel      = ds;
        bus2.dst_bcast    = bc;
        step();
        bus2.rec_complete = 4'b0000;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        @(posedge clk);
        #1 reset = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] eg;
        logic [3:0] ew;
        logic [3:0] ep;

        bus.rec_complete  = 4'b0000;
        bus.dst_sel       = 8'h00;
        bus.dst_bcast     = 4'b0000;
        bus.egress_full   = 4'b0000;
        bus2.rec_complete = 4'b0000;
        bus2.dst_sel      = 8'h00;
        bus2.dst_bcast    = 4'b0000;
        bus2.egress_full  = 4'b0000;

        // Reset state
        step();
        check("rst_grant",   bus.grant,    8'h0);
        check("rst_wr_en",   bus.wr_en,    8'h0);
        check("rst_pending", bus.pending,  8'h0);
        check("rst_busy",    bus.busy,     8'h0);
        check("rst_drop",    bus.drop_cnt, 8'h0);
        do_reset();

        // Single packet port1 -> port2
        pulse(4'b0010, 8'h08, 4'b0000);                     // t+1
        check("t1_pend_t1",  bus.pending, 8'h2);
        check("t1_grant_t1", bus.grant,   8'h0);
        step();                                              // t+2
        check("t1_grant_t2", bus.grant, 8'h2);
        check("t1_busy_t2",  bus.busy,  8'h1);
        check("t1_wr_t2",    bus.wr_en, 8'h0);
        step();                                              // t+3
        check("t1_grant_t3", bus.grant, 8'h2);
        check("t1_wr_t3",    bus.wr_en, 8'h0);
        step();                                              // t+4
        check("t1_grant_t4", bus.grant, 8'h2);
        check("t1_wr_t4",    bus.wr_en, 8'h4);
        step();                                              // t+5
        check("t1_grant_t5", bus.grant, 8'h2);
        check("t1_wr_t5",    bus.wr_en, 8'h0);
        step();                                              // t+6
        check("t1_grant_t6", bus.grant,    8'h0);
        check("t1_pend_t6",  bus.pending,  8'h0);
        check("t1_busy_t6",  bus.busy,     8'h0);
        check("t1_drop",     bus.drop_cnt, 8'h0);

        // All four ports at once, unicast 0->1, 1->2, 2->3, 3->0
        do_reset();
        pulse(4'b1111, 8'h39, 4'b0000);
        check("t2_pend_all", bus.pending, 8'hF);
        for (int k = 0; k < 4; k++) begin
            for (int off = 0; off < 5; off++) begin
                step();
                eg = (off < 4) ? 4'(1 << k) : 4'b0000;
                ew = (off == 2) ? 4'(1 << ((k + 1) % 4)) : 4'b0000;
                check($sformatf("t2_grant_k%0d_o%0d", k, off), bus.grant, eg);
                check($sformatf("t2_wr_k%0d_o%0d", k, off),    bus.wr_en, ew);
                if (off == 4) begin
                    ep = 4'((4'hF << (k + 1)) & 4'hF);
                    check($sformatf("t2_pend_k%0d", k), bus.pending, ep);
                    check($sformatf("t2_busy_k%0d", k), bus.busy,    8'h0);
                end
            end
        end
        check("t2_drop", bus.drop_cnt, 8'h0);

        // Port 2 broadcast with egress FIFO 0 full
        do_reset();
        bus.egress_full = 4'b0001;
        pulse(4'b0100, 8'h00, 4'b0100);                     // t+1
        step();                                              // t+2
        check("t3_grant_t2", bus.grant, 8'h4);
        step();                                              // t+3
        step();                                              // t+4
`ifdef HUB_SCHED_FULL_WAIT_EN
        check("t3_wr_wait_t4",  bus.wr_en, 8'h0);
        check("t3_busy_t4",     bus.busy,  8'h1);
        step();                                              // t+5
        check("t3_wr_wait_t5",  bus.wr_en, 8'h0);
        check("t3_grant_t5",    bus.grant, 8'h4);
        bus.egress_full = 4'b0000;
        step();                                              // t+6
        check("t3_wr_t6",       bus.wr_en, 8'hB);
        check("t3_grant_t6",    bus.grant, 8'h4);
        step();                                              // t+7
        check("t3_wr_t7",       bus.wr_en, 8'h0);
        step();                                              // t+8
        check("t3_grant_t8",    bus.grant,    8'h0);
        check("t3_pend_t8",     bus.pending,  8'h0);
        check("t3_drop",        bus.drop_cnt, 8'h0);
`else
        check("t3_wr_t4",       bus.wr_en,    8'hA);
        check("t3_drop_t4",     bus.drop_cnt, 8'h1);
        step();                                              // t+5
        check("t3_wr_t5",       bus.wr_en, 8'h0);
        step();                                              // t+6
        check("t3_grant_t6",    bus.grant,    8'h0);
        check("t3_pend_t6",     bus.pending,  8'h0);
        check("t3_drop_t6",     bus.drop_cnt, 8'h1);
        bus.egress_full = 4'b0000;
`endif

        // Port 0 self-addressed, overrun, then re-capture in RELEASE
        do_reset();
        pulse(4'b0001, 8'h00, 4'b0000);                     // t+1
        check("t4_pend_t1", bus.pending, 8'h1);
        step();                                              // t+2
        step();                                              // t+3
        step();                                              // t+4 WRITE
        check("t4_wr_t4",    bus.wr_en,    8'h0);
        check("t4_drop_t4",  bus.drop_cnt, 8'h1);
        check("t4_grant_t4", bus.grant,    8'h1);
        pulse(4'b0001, 8'h00, 4'b0000);                     // t+5 RELEASE
        check("t4_drop_ovr", bus.drop_cnt, 8'h2);
        check("t4_grant_t5", bus.grant,    8'h1);
        pulse(4'b0001, 8'h01, 4'b0000);                     // t+6
        check("t4_pend_rel", bus.pending,  8'h1);
        check("t4_grant_t6", bus.grant,    8'h0);
        check("t4_drop_rel", bus.drop_cnt, 8'h2);
        step();                                              // t+7
        check("t4_grant_t7", bus.grant, 8'h1);
        step();                                              // t+8
        step();                                              // t+9
        check("t4_wr_t9",    bus.wr_en, 8'h2);
        step();                                              // t+10
        step();                                              // t+11
        check("t4_pend_end", bus.pending,  8'h0);
        check("t4_drop_end", bus.drop_cnt, 8'h2);

        // Saturation with a 2-bit drop counter
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            pulse2(4'b0001, 8'h00, 4'b0000);
            repeat (6) step();
            check($sformatf("t5_sat_n%0d", n), bus2.drop_cnt, 8'((n < 3) ? n : 3));
        end
        check("t5_wr", bus2.wr_en, 8'h0);

        // Reset in the middle of a GRANT phase
        do_reset();
        pulse(4'b0010, 8'h08, 4'b0000);                     // t+1
        step();                                              // t+2
        check("t6_grant_pre", bus.grant, 8'h2);
        reset = 1'b0;
        #1;
        check("t6_grant_rst", bus.grant,    8'h0);
        check("t6_wr_rst",    bus.wr_en,    8'h0);
        check("t6_pend_rst",  bus.pending,  8'h0);
        check("t6_busy_rst",  bus.busy,     8'h0);
        check("t6_drop_rst",  bus.drop_cnt, 8'h0);
        step();
        @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("t6_stale_wr_%0d", c),    bus.wr_en, 8'h0);
            check($sformatf("t6_stale_grant_%0d", c), bus.grant, 8'h0);
        end
        pulse(4'b1000, 8'h40, 4'b0000);                     // t+1
        check("t6_pend_t1",  bus.pending, 8'h8);
        step();                                              // t+2
        check("t6_grant_t2", bus.grant, 8'h8);
        check("t6_wr_t2",    bus.wr_en, 8'h0);
        step();                                              // t+3
        check("t6_wr_t3",    bus.wr_en, 8'h0);
        step();                                              // t+4
        check("t6_wr_t4",    bus.wr_en, 8'h2);
        check("t6_grant_t4", bus.grant, 8'h8);
        step();                                              // t+5
        step();                                              // t+6
        check("t6_pend_end",  bus.pending, 8'h0);
        check("t6_grant_end", bus.grant,   8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hub_fwd_scheduler.md
Name: hub_fwd_scheduler

Overview:
Scheduler that shares the hub's single distribution path between the four ports. It latches per-port receive-complete events and their destination info, and picks one source at a time by round-robin. It drives the distributor source-select (grant) and issues one-cycle write strobes into the egress FIFOs, skipping full FIFOs and counting drops. It sits between the Port receive side, the distributor and the four egress FIFOs.

Parameters:
HOLD_CYCLES, 2, cycles grant is held before the write strobe so the distributor data mux settles (min 1)
DROP_CNT_W, 8, width of saturating drop counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rec_complete  in  4  one-cycle pulse per port: packet fully received
dst_sel  in  8  2-bit destination port per source port (bits [2i+1:2i] = port i), sampled with rec_complete[i]
dst_bcast  in  4  broadcast flag per source port, sampled with rec_complete[i]
egress_full  in  4  is_full of each egress FIFO
grant  out  4  one-hot source select to distributor; 0 when idle
wr_en  out  4  one-cycle write strobe per egress FIFO
pending  out  4  latched-but-unserved packet flags
busy  out  1  high whenever state != IDLE
drop_cnt  out  DROP_CNT_W  saturating count of dropped/overrun packets

Behaviour:
- Reset (reset=0, async): state IDLE; grant, wr_en, pending, busy = 0; drop_cnt = 0; rr pointer = 3, so port 0 has first priority.
- Capture: rec_complete[i] with pending[i]=0 sets pending[i] and stores dst_sel/dst_bcast for port i.
- rec_complete[i] with pending[i]=1 (not in that port's RELEASE cycle) is an overrun: pulse ignored, stored dst unchanged, drop_cnt+1.
- rec_complete[i] during RELEASE of port i: the clear and the set coincide; pending[i] stays 1 with the new dst and is served as a new packet, with no overrun.
- Any number of ports may pulse in the same cycle. All are captured.
- FSM: IDLE -> GRANT -> WRITE -> RELEASE -> IDLE.
- IDLE: if pending != 0, select the first set bit scanning from rr+1 upward, modulo 4. The next state is GRANT with grant = onehot(src), registered.
- GRANT: grant held for HOLD_CYCLES cycles via a counter, then WRITE.
- WRITE, exactly one cycle, grant still high:
  - mask = dst_bcast ? (4'b1111 & ~onehot(src)) : onehot(dst).
  - If dst == src (non-broadcast), mask = 0.
  - wr_en = mask & ~egress_full, registered so it is high exactly during the WRITE cycle.
  - drop_cnt+1 if mask == 0, or if any mask bit is blocked by full (one increment per packet).
- RELEASE: grant=0, wr_en=0, clear pending[src], rr = src, then IDLE.
- Latency: rec_complete at cycle t gives pending high at t+1, grant high at t+2, and wr_en at t+2+HOLD_CYCLES. A packet occupies HOLD_CYCLES+3 cycles; back-to-back service has no extra idle cycle beyond RELEASE->IDLE.
- drop_cnt saturates at all-ones; it never wraps. Simultaneous increment sources in one cycle (overrun plus WRITE drop) add their sum, saturating.
- grant is one-hot or zero at all times; wr_en never has the src bit set.
- Reset mid-packet aborts immediately. No partial wr_en is emitted after reset deasserts.

Optional Feature:
HUB_SCHED_FULL_WAIT_EN
- Defined: WRITE does not drop on full. The FSM stays in WRITE with grant held and wr_en=0 until (mask & egress_full)==0, then pulses wr_en=mask for one cycle and proceeds to RELEASE. In this mode the only drops are mask==0 packets and overruns. busy remains high while waiting.
- Undefined: drop-on-full behaviour as above.

Test Plan:
- Reset, then a single rec_complete[1] with dst_sel port1=2, HOLD_CYCLES=2 -> grant=4'b0010 at t+2..t+5; wr_en=4'b0100 only at t+4; pending[1] clear by t+6; drop_cnt=0.
- rec_complete=4'b1111 in the same cycle, all unicast to distinct non-self ports -> grants in order 0,1,2,3, each spaced 5 cycles; exactly four single wr_en pulses; pending returns to 0.
- Port 2 broadcast with egress_full=4'b0001 (macro off) -> wr_en=4'b1010; drop_cnt=1. With macro on: wr_en stays 0 until full drops, then wr_en=4'b1011.
- Port 0 unicast to itself -> no wr_en; drop_cnt=1. A second rec_complete[0] while pending -> drop_cnt=2. A pulse exactly in port 0's RELEASE cycle -> served again, no increment.
- DROP_CNT_W=2, five self-addressed packets -> drop_cnt saturates at 3.
- Assert reset during GRANT -> grant, wr_en, pending, busy = 0 immediately; after release a new rec_complete[3] is served first at port 3 with no stale wr_en.
